// File: rtl/jump_target_unit.sv
// rtl/jump_target_unit.sv - branch target table with stream bulk-load and PC jump responder
// Optional range check on lookups is enabled by defining JT_BOUNDS_CHECK_EN.
module jump_target_unit #(
  parameter int ADDR_W = 10,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              init_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              reload,
  input  logic              branch_taken,
  input  logic [IDX_W-1:0]  jump_idx,
  input  logic              read_jump,
  output logic              jump_en,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              halt,
  output logic [IDX_W:0]    load_cnt,
  output logic              bad_idx
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [IDX_W:0] LAST_IDX = (IDX_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

  state_t            state_q, state_d;
  logic [IDX_W:0]    wptr_q, wptr_d;
  logic [IDX_W:0]    load_cnt_q, load_cnt_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [ADDR_W-1:0] tbl_q [DEPTH];
  logic [ADDR_W-1:0] tbl_d [DEPTH];
`ifdef JT_BOUNDS_CHECK_EN
  logic              tgt_ok_q, tgt_ok_d;
  logic              bad_q, bad_d;
`endif

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    load_cnt_d = load_cnt_q;
    tgt_d      = tgt_q;
    tbl_d      = tbl_q;
    ld_ready   = 1'b0;
    halt       = 1'b1;
    jump_en    = 1'b0;
`ifdef JT_BOUNDS_CHECK_EN
    tgt_ok_d   = tgt_ok_q;
    bad_d      = bad_q;
`endif

    case (state_q)
      EMPTY: state_d = LOAD;
      LOAD: begin
        // A reload restarts the burst, so the word offered alongside it is refused.
        ld_ready = !reload;
        if (ld_valid && !reload) begin
          tbl_d[wptr_q[IDX_W-1:0]] = ld_data;
          wptr_d     = wptr_q + 1'b1;
          load_cnt_d = wptr_q + 1'b1;
          if (ld_last || wptr_q == LAST_IDX) begin
            state_d = READY;
          end
        end
      end
      READY: begin
        halt = 1'b0;
`ifdef JT_BOUNDS_CHECK_EN
        jump_en = read_jump && tgt_ok_q;
        if (branch_taken) begin
          if ({1'b0, jump_idx} >= load_cnt_q) begin
            tgt_d    = '0;
            tgt_ok_d = 1'b0;
            bad_d    = 1'b1;
          end else begin
            tgt_d    = tbl_q[jump_idx];
            tgt_ok_d = 1'b1;
          end
        end
`else
        jump_en = read_jump;
        if (branch_taken) begin
          tgt_d = tbl_q[jump_idx];
        end
`endif
      end
      default: state_d = EMPTY;
    endcase

    if (reload) begin
      state_d    = LOAD;
      wptr_d     = '0;
      load_cnt_d = '0;
`ifdef JT_BOUNDS_CHECK_EN
      bad_d      = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q    <= EMPTY;
      wptr_q     <= '0;
      load_cnt_q <= '0;
      tgt_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
`ifdef JT_BOUNDS_CHECK_EN
      tgt_ok_q   <= 1'b1;
      bad_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      load_cnt_q <= load_cnt_d;
      tgt_q      <= tgt_d;
      tbl_q      <= tbl_d;
`ifdef JT_BOUNDS_CHECK_EN
      tgt_ok_q   <= tgt_ok_d;
      bad_q      <= bad_d;
`endif
    end
  end

  assign jump_addr = tgt_q;
  assign load_cnt  = load_cnt_q;
`ifdef JT_BOUNDS_CHECK_EN
  assign bad_idx   = bad_q;
`else
  assign bad_idx   = 1'b0;
`endif

endmodule

// File: tb/tb_jump_target_unit.sv
// tb/tb_jump_target_unit.sv - directed self-checking bench for jump_target_unit
module tb_jump_target_unit;

  logic       clk = 1'b0;
  logic       init_n;
  logic       ld_valid;
  logic       ld_ready;
  logic [9:0] ld_data;
  logic       ld_last;
  logic       reload;
  logic       branch_taken;
  logic [4:0] jump_idx;
  logic       read_jump;
  logic       jump_en;
  logic [9:0] jump_addr;
  logic       halt;
  logic [5:0] load_cnt;
  logic       bad_idx;

  int checks = 0;
  int errors = 0;

`ifdef JT_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  jump_target_unit #(.ADDR_W(10), .IDX_W(5)) dut (
    .clk(clk), .init_n(init_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .reload(reload),
    .branch_taken(branch_taken), .jump_idx(jump_idx), .read_jump(read_jump),
    .jump_en(jump_en), .jump_addr(jump_addr), .halt(halt),
    .load_cnt(load_cnt), .bad_idx(bad_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input string tag, input logic [9:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    #1;
    check(tag, ld_ready, 1'b1);
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [4:0] idx,
                        input logic [9:0] exp_addr, input logic exp_en);
    branch_taken = 1'b1;
    jump_idx     = idx;
    tick();
    branch_taken = 1'b0;
    read_jump    = 1'b1;
    #1;
    check({tag, "_en"}, jump_en, exp_en);
    check({tag, "_addr"}, jump_addr, exp_addr);
    read_jump = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ld_ready"}, ld_ready, 1'b0);
    check({tag, "_jump_en"}, jump_en, 1'b0);
    check({tag, "_jump_addr"}, jump_addr, 10'h000);
    check({tag, "_halt"}, halt, 1'b1);
    check({tag, "_load_cnt"}, load_cnt, 6'd0);
    check({tag, "_bad_idx"}, bad_idx, 1'b0);
  endtask

  initial begin
    init_n = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; reload = 1'b0;
    branch_taken = 1'b0; jump_idx = '0; read_jump = 1'b0;
    #12;
    check_reset_outputs("rst");
    #5 init_n = 1'b1;
    tick();
    check("load_halt", halt, 1'b1);
    check("load_ready", ld_ready, 1'b1);

    // First burst: three words with ld_last on the third
    load_word("ld3_0", 10'h010, 1'b0);
    load_word("ld3_1", 10'h155, 1'b0);
    check("ld3_halt_mid", halt, 1'b1);
    load_word("ld3_2", 10'h3FF, 1'b1);
    check("ld3_halt", halt, 1'b0);
    check("ld3_ready", ld_ready, 1'b0);
    check("ld3_cnt", load_cnt, 6'd3);

    lookup("lk1", 5'd1, 10'h155, 1'b1);
    #1;
    check("lk1_noread_en", jump_en, 1'b0);
    check("lk1_noread_addr", jump_addr, 10'h155);

    // Back-to-back lookups: the later one wins
    branch_taken = 1'b1; jump_idx = 5'd0;
    tick();
    jump_idx = 5'd2;
    tick();
    branch_taken = 1'b0;
    #1;
    check("b2b_addr", jump_addr, 10'h3FF);

    // reload together with read_jump in READY still grants the jump
    reload = 1'b1; read_jump = 1'b1;
    #1;
    check("rld_jump_en", jump_en, 1'b1);
    check("rld_ld_ready", ld_ready, 1'b0);
    tick();
    reload = 1'b0; read_jump = 1'b0;
    check("rld_halt", halt, 1'b1);
    check("rld_cnt", load_cnt, 6'd0);

    // A word offered with reload in LOAD is refused
    reload = 1'b1; ld_valid = 1'b1; ld_data = 10'h2AA;
    #1;
    check("rld_refuse", ld_ready, 1'b0);
    tick();
    reload = 1'b0; ld_valid = 1'b0;
    check("rld_refuse_cnt", load_cnt, 6'd0);

    load_word("ld1_0", 10'h0AA, 1'b1);
    check("ld1_cnt", load_cnt, 6'd1);
    lookup("lk_idx0", 5'd0, 10'h0AA, 1'b1);
    tick();
    lookup("lk_idx2", 5'd2, BC ? 10'h000 : 10'h3FF, !BC);
    check("lk_idx2_bad", bad_idx, BC);

    reload = 1'b1;
    tick();
    reload = 1'b0;
    check("bad_cleared", bad_idx, 1'b0);

    // Full table: 32 words with no ld_last
    for (int i = 0; i < 32; i++) begin
      load_word($sformatf("ld32_%0d", i), 10'(i * 3 + 7), 1'b0);
    end
    check("ld32_halt", halt, 1'b0);
    check("ld32_cnt", load_cnt, 6'd32);
    ld_valid = 1'b1;
    #1;
    check("ld32_extra", ld_ready, 1'b0);
    ld_valid = 1'b0;
    lookup("lk_idx31", 5'd31, 10'h064, 1'b1);
    lookup("lk_idx5", 5'd5, 10'h016, 1'b1);

    // Reload, two words, then control activity during LOAD
    reload = 1'b1;
    tick();
    reload = 1'b0;
    load_word("ld2_0", 10'h111, 1'b0);
    load_word("ld2_1", 10'h222, 1'b0);
    branch_taken = 1'b1; jump_idx = 5'd1; read_jump = 1'b1;
    #1;
    check("inload_en", jump_en, 1'b0);
    tick();
    branch_taken = 1'b0; read_jump = 1'b1;
    #1;
    check("inload_en2", jump_en, 1'b0);
    check("inload_addr", jump_addr, 10'h016);
    check("inload_halt", halt, 1'b1);
    read_jump = 1'b0;

    // Asynchronous reset mid-LOAD, away from any clock edge
    #2 init_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    #3 init_n = 1'b1;
    tick();
    tick();
    load_word("ld_post", 10'h123, 1'b1);
    check("post_cnt", load_cnt, 6'd1);
    lookup("lk_cleared", 5'd1, 10'h000, !BC);
    lookup("lk_post0", 5'd0, 10'h123, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
